// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and colour types for the VGA path
// (sync generator, renderer, clock divider).
package vga_pkg;

    localparam int H_VIS = 640;
    localparam int H_FP  = 16;
    localparam int H_SP  = 96;
    localparam int H_BP  = 48;
    localparam int V_VIS = 480;
    localparam int V_FP  = 10;
    localparam int V_SP  = 2;
    localparam int V_BP  = 33;

    localparam int H_TOT = H_VIS + H_FP + H_SP + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SP + V_BP;

    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SP;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SP;

    localparam logic SYNC_POL = 1'b0;

    // Counters are 10 bits wide, so every total must stay at or below 1023.
    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef logic [11:0] rgb_t;
    localparam rgb_t RGB_BLANK = 12'h000;

    typedef struct packed {
        logic hsync;
        logic vsync;
        rgb_t rgb;
    } out_stage_t;

    function automatic logic in_window(input cnt_t c, input cnt_t lo, input cnt_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bus between the sync generator and the renderer: strobe and coordinate
// out to the renderer, colour back in, syncs and colour on to the DAC.
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic pix_en;
    cnt_t pix_x;
    cnt_t pix_y;
    logic de;
    rgb_t rgb_in;
    logic hsync;
    logic vsync;
    rgb_t rgb_out;
    logic frame_tick;

    modport master (
        input  pix_en,
        input  rgb_in,
        output pix_x,
        output pix_y,
        output de,
        output hsync,
        output vsync,
        output rgb_out,
        output frame_tick
    );

    modport slave (
        output pix_en,
        output rgb_in,
        input  pix_x,
        input  pix_y,
        input  de,
        input  hsync,
        input  vsync,
        input  rgb_out,
        input  frame_tick
    );

endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing: stage 0 holds the h/v counters and data-enable, stage 1
// registers syncs and colour one pixel later so they reach the pins aligned.
module vga_sync_gen #(
    parameter int   H_VIS    = vga_pkg::H_VIS,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SP     = vga_pkg::H_SP,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_VIS    = vga_pkg::V_VIS,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SP     = vga_pkg::V_SP,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic             clk,
    input  logic             clr_n,
    vga_sync_gen_if.master   vif
);
    import vga_pkg::*;

    localparam int LINE_TOT    = H_VIS + H_FP + H_SP + H_BP;
    localparam int FRAME_LINES = V_VIS + V_FP + V_SP + V_BP;

    localparam cnt_t H_LAST  = cnt_t'(LINE_TOT - 1);
    localparam cnt_t V_LAST  = cnt_t'(FRAME_LINES - 1);
    localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
    localparam cnt_t HS_LO   = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_HI   = cnt_t'(H_VIS + H_FP + H_SP);
    localparam cnt_t VS_LO   = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_HI   = cnt_t'(V_VIS + V_FP + V_SP);

    localparam out_stage_t OUT_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, rgb: RGB_BLANK};

    cnt_t       h_cnt_q, h_cnt_d;
    cnt_t       v_cnt_q, v_cnt_d;
    logic       de_q, de_d;
    out_stage_t out_q, out_d;
    logic       frame_tick_q, frame_tick_d;

    // Counters rest on the last position so the first strobe lands on (0,0).
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            h_cnt_q      <= H_LAST;
            v_cnt_q      <= V_LAST;
            de_q         <= 1'b0;
            out_q        <= OUT_RST;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            de_q         <= de_d;
            out_q        <= out_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    always_comb begin
        h_cnt_d      = h_cnt_q;
        v_cnt_d      = v_cnt_q;
        de_d         = de_q;
        out_d        = out_q;
        frame_tick_d = 1'b0;

        if (vif.pix_en) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
            end else begin
                h_cnt_d = h_cnt_q + cnt_t'(1);
            end

            de_d = (h_cnt_d < H_VIS_C) && (v_cnt_d < V_VIS_C);

            // Stage 1 looks at the pre-update coordinate, one pixel behind stage 0.
            out_d.hsync = in_window(h_cnt_q, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
            out_d.vsync = in_window(v_cnt_q, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
            out_d.rgb   = de_q ? vif.rgb_in : RGB_BLANK;

            frame_tick_d = (h_cnt_d == '0) && (v_cnt_d == '0);
        end
    end

    assign vif.pix_x      = h_cnt_q;
    assign vif.pix_y      = v_cnt_q;
    assign vif.de         = de_q;
    assign vif.hsync      = out_q.hsync;
    assign vif.vsync      = out_q.vsync;
    assign vif.rgb_out    = out_q.rgb;
    assign vif.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-size instance and a shrunken-timing instance
// share stimulus; both are checked every cycle against an arithmetic raster model.
module tb_vga_sync_gen;
    import vga_pkg::*;

    localparam int S_HV = 16, S_HF = 2, S_HS = 4, S_HB = 3;
    localparam int S_VV = 6,  S_VF = 1, S_VS = 2, S_VB = 1;

    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
    } tim_t;

    typedef struct {
        int x, y, de, hs, vs, rgb;
    } exp_t;

    typedef struct {
        int n;
        int x, y, de, hs, vs, rgb, ft;
    } vec_t;

    logic clk    = 1'b0;
    logic clr_n  = 1'b1;
    logic pix_en = 1'b0;
    rgb_t rgb_in = '0;

    always #5 clk = ~clk;

    vga_sync_gen_if vif_f ();
    vga_sync_gen_if vif_s ();

    assign vif_f.pix_en = pix_en;
    assign vif_f.rgb_in = rgb_in;
    assign vif_s.pix_en = pix_en;
    assign vif_s.rgb_in = rgb_in;

    vga_sync_gen dut_f (
        .clk   (clk),
        .clr_n (clr_n),
        .vif   (vif_f.master)
    );

    vga_sync_gen #(
        .H_VIS(S_HV), .H_FP(S_HF), .H_SP(S_HS), .H_BP(S_HB),
        .V_VIS(S_VV), .V_FP(S_VF), .V_SP(S_VS), .V_BP(S_VB),
        .SYNC_POL(1'b0)
    ) dut_s (
        .clk   (clk),
        .clr_n (clr_n),
        .vif   (vif_s.master)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    tim_t tim_f, tim_s;
    bit   mon_en   = 1'b0;

    // Model state: strobes since reset, colour sampled on the last strobe.
    int   n_m      = 0;
    int   rgb_m    = 0;
    bit   tick_f_m = 1'b0;
    bit   tick_s_m = 1'b0;
    int   ft_cnt_s = 0;

    function automatic int tot_of(input tim_t t);
        return (t.hv + t.hf + t.hs + t.hb) * (t.vv + t.vf + t.vs + t.vb);
    endfunction

    // Position after k strobes is raster index k-1 (mod frame); k=0 is the last index.
    function automatic exp_t model(input tim_t t, input int n, input int rgb_s);
        exp_t e;
        int ht, tot, p, pp, px, py;
        ht   = t.hv + t.hf + t.hs + t.hb;
        tot  = tot_of(t);
        p    = ((n - 1) % tot + tot) % tot;
        e.x  = p % ht;
        e.y  = p / ht;
        e.de = (e.x < t.hv && e.y < t.vv) ? 1 : 0;
        if (n == 0) begin
            e.hs  = 1;
            e.vs  = 1;
            e.rgb = 0;
        end else begin
            pp    = ((n - 2) % tot + tot) % tot;
            px    = pp % ht;
            py    = pp / ht;
            e.hs  = (px >= t.hv + t.hf && px < t.hv + t.hf + t.hs) ? 0 : 1;
            e.vs  = (py >= t.vv + t.vf && py < t.vv + t.vf + t.vs) ? 0 : 1;
            e.rgb = (px < t.hv && py < t.vv) ? rgb_s : 0;
        end
        return e;
    endfunction

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            n_m      <= 0;
            rgb_m    <= 0;
            tick_f_m <= 1'b0;
            tick_s_m <= 1'b0;
        end else if (pix_en) begin
            n_m      <= n_m + 1;
            rgb_m    <= int'(rgb_in);
            tick_f_m <= (n_m % tot_of(tim_f)) == 0;
            tick_s_m <= (n_m % tot_of(tim_s)) == 0;
        end else begin
            tick_f_m <= 1'b0;
            tick_s_m <= 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e, input int ft_e,
                           input int x, input int y, input int de, input int hs,
                           input int vs, input int rgb, input int ft);
        check({tag, ".pix_x"}, x, e.x);
        check({tag, ".pix_y"}, y, e.y);
        check({tag, ".de"}, de, e.de);
        check({tag, ".hsync"}, hs, e.hs);
        check({tag, ".vsync"}, vs, e.vs);
        check({tag, ".rgb_out"}, rgb, e.rgb);
        check({tag, ".frame_tick"}, ft, ft_e);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            cmp_all("mon_f", model(tim_f, n_m, rgb_m), int'(tick_f_m),
                    int'(vif_f.pix_x), int'(vif_f.pix_y), int'(vif_f.de), int'(vif_f.hsync),
                    int'(vif_f.vsync), int'(vif_f.rgb_out), int'(vif_f.frame_tick));
            cmp_all("mon_s", model(tim_s, n_m, rgb_m), int'(tick_s_m),
                    int'(vif_s.pix_x), int'(vif_s.pix_y), int'(vif_s.de), int'(vif_s.hsync),
                    int'(vif_s.vsync), int'(vif_s.rgb_out), int'(vif_s.frame_tick));
        end
    end

    always @(negedge clk) begin
        if (vif_s.frame_tick === 1'b1) ft_cnt_s <= ft_cnt_s + 1;
    end

    task automatic apply_vec(input vec_t v);
        string t;
        t = $sformatf("vec%0d", v.n);
        check({t, ".pix_x"}, int'(vif_f.pix_x), v.x);
        check({t, ".pix_y"}, int'(vif_f.pix_y), v.y);
        check({t, ".de"}, int'(vif_f.de), v.de);
        check({t, ".hsync"}, int'(vif_f.hsync), v.hs);
        check({t, ".vsync"}, int'(vif_f.vsync), v.vs);
        check({t, ".rgb_out"}, int'(vif_f.rgb_out), v.rgb);
        check({t, ".frame_tick"}, int'(vif_f.frame_tick), v.ft);
        $display("vec strobe=%0d x=%0d y=%0d de=%0d hs=%0d vs=%0d rgb=%03h ft=%0d",
                 v.n, vif_f.pix_x, vif_f.pix_y, vif_f.de, vif_f.hsync, vif_f.vsync,
                 vif_f.rgb_out, vif_f.frame_tick);
    endtask

    task automatic check_rst(input string tag, input int x, input int y, input int de,
                             input int hs, input int vs, input int rgb, input int ft,
                             input int xr, input int yr);
        check({tag, ".pix_x"}, x, xr);
        check({tag, ".pix_y"}, y, yr);
        check({tag, ".de"}, de, 0);
        check({tag, ".hsync"}, hs, 1);
        check({tag, ".vsync"}, vs, 1);
        check({tag, ".rgb_out"}, rgb, 0);
        check({tag, ".frame_tick"}, ft, 0);
    endtask

    vec_t vecs[13];

    initial begin
        int vi, hs_low, n_start, n_end, ft_base, exp_frames, gap;

        tim_f = '{H_VIS, H_FP, H_SP, H_BP, V_VIS, V_FP, V_SP, V_BP};
        tim_s = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB};

        //          n    x    y    de hs vs rgb     ft
        vecs[0]  = '{0,   799, 524, 0, 1, 1, 0,      0};
        vecs[1]  = '{1,   0,   0,   1, 1, 1, 0,      1};
        vecs[2]  = '{2,   1,   0,   1, 1, 1, 'hF00,  0};
        vecs[3]  = '{640, 639, 0,   1, 1, 1, 'hF00,  0};
        vecs[4]  = '{641, 640, 0,   0, 1, 1, 'hF00,  0};
        vecs[5]  = '{642, 641, 0,   0, 1, 1, 0,      0};
        vecs[6]  = '{657, 656, 0,   0, 1, 1, 0,      0};
        vecs[7]  = '{658, 657, 0,   0, 0, 1, 0,      0};
        vecs[8]  = '{753, 752, 0,   0, 0, 1, 0,      0};
        vecs[9]  = '{754, 753, 0,   0, 1, 1, 0,      0};
        vecs[10] = '{800, 799, 0,   0, 1, 1, 0,      0};
        vecs[11] = '{801, 0,   1,   1, 1, 1, 0,      0};
        vecs[12] = '{802, 1,   1,   1, 1, 1, 'hF00,  0};

        #2 clr_n = 1'b0;
        #1 mon_en = 1'b1;
        @(negedge clk);
        apply_vec(vecs[0]);
        @(posedge clk);
        #1 clr_n = 1'b1;

        // One full line plus two strobes, strobe every 4 clk, constant red.
        rgb_in = 12'hF00;
        hs_low = 0;
        vi     = 1;
        pix_en = 1'b1;
        for (int n = 1; n <= 802; n++) begin
            @(posedge clk);
            #1 pix_en = 1'b0;
            @(negedge clk);
            if (n <= 801 && vif_f.hsync == 1'b0) hs_low++;
            if (vi < 13 && vecs[vi].n == n) begin
                apply_vec(vecs[vi]);
                vi++;
            end
            repeat (3) @(posedge clk);
            #1;
            if (n < 802) pix_en = 1'b1;
        end
        check("hsync_low_strobes", hs_low, 96);
        $display("line: hsync low for %0d strobes", hs_low);

        // Random spacing (including back-to-back strobes) and random colour.
        n_start = n_m;
        ft_base = ft_cnt_s;
        for (int i = 0; i < 1500; i++) begin
            rgb_in = 12'($urandom_range(0, 4095));
            pix_en = 1'b1;
            @(posedge clk);
            #1;
            gap = int'($urandom_range(0, 3));
            if (gap > 0) begin
                pix_en = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        pix_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_end = n_m;
        exp_frames = 0;
        for (int k = n_start + 1; k <= n_end; k++) begin
            if ((k - 1) % tot_of(tim_s) == 0) exp_frames++;
        end
        check("frame_ticks_small", ft_cnt_s - ft_base, exp_frames);
        $display("random: %0d strobes, %0d small-raster frames", n_end - n_start, ft_cnt_s - ft_base);

        // Idle mid-line: everything holds, frame_tick stays low.
        repeat (100) @(posedge clk);
        #1;
        $display("hold: 100 idle cycles at strobe %0d", n_m);

        // Asynchronous reset mid-frame, then restart at (0,0).
        clr_n = 1'b0;
        #1;
        check_rst("rst_f", int'(vif_f.pix_x), int'(vif_f.pix_y), int'(vif_f.de), int'(vif_f.hsync),
                  int'(vif_f.vsync), int'(vif_f.rgb_out), int'(vif_f.frame_tick), 799, 524);
        check_rst("rst_s", int'(vif_s.pix_x), int'(vif_s.pix_y), int'(vif_s.de), int'(vif_s.hsync),
                  int'(vif_s.vsync), int'(vif_s.rgb_out), int'(vif_s.frame_tick), 24, 9);
        $display("reset: outputs f=(%0d,%0d) s=(%0d,%0d)", vif_f.pix_x, vif_f.pix_y, vif_s.pix_x, vif_s.pix_y);
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b1;
        rgb_in = 12'h0A5;
        repeat (2) @(posedge clk);
        #1 pix_en = 1'b1;
        @(posedge clk);
        #1 pix_en = 1'b0;
        @(negedge clk);
        check("restart_f.pix_x", int'(vif_f.pix_x), 0);
        check("restart_f.pix_y", int'(vif_f.pix_y), 0);
        check("restart_f.frame_tick", int'(vif_f.frame_tick), 1);
        check("restart_s.pix_x", int'(vif_s.pix_x), 0);
        check("restart_s.pix_y", int'(vif_s.pix_y), 0);
        check("restart_s.de", int'(vif_s.de), 1);
        @(posedge clk);
        #1 pix_en = 1'b1;
        @(posedge clk);
        #1 pix_en = 1'b0;
        @(negedge clk);
        check("restart_f.rgb_out", int'(vif_f.rgb_out), 'h0A5);
        check("restart_s.pix_x1", int'(vif_s.pix_x), 1);
        $display("restart: f=(%0d,%0d) rgb=%03h", vif_f.pix_x, vif_f.pix_y, vif_f.rgb_out);

        repeat (2) @(posedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Consumes the 25 MHz pixel rate produced by the clock divider, here delivered as a one-cycle enable strobe in the 100 MHz `clk` domain. Generates 640x480@60 VGA raster timing: horizontal and vertical counters, sync pulses, and the current pixel coordinate. Renderer logic (bird, pipes, background) uses the coordinate to compute colour. The block returns that colour to the DAC pins, delayed by one pixel so it stays aligned with the syncs.

## Interface
Parameters:
- `H_VIS`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SP`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_VIS`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SP`, 2, vsync width
- `V_BP`, 33, vertical back porch
- `SYNC_POL`, 0, active sync level (0 = active-low)

Ports:
- `clk`  in  1  system clock, 100 MHz
- `clr_n`  in  1  asynchronous, active-low reset
- `pix_en`  in  1  pixel strobe, one `clk` cycle high every 4 cycles
- `pix_x`  out  10  current horizontal count
- `pix_y`  out  10  current vertical count
- `de`  out  1  high when (`pix_x`,`pix_y`) is visible
- `rgb_in`  in  12  renderer colour for the previous coordinate (4:4:4)
- `hsync`  out  1  horizontal sync, aligned to `rgb_out`
- `vsync`  out  1  vertical sync, aligned to `rgb_out`
- `rgb_out`  out  12  colour to DAC; 0 during blanking
- `frame_tick`  out  1  one-`clk` pulse at the start of each frame

## Operation
- Derived constants:
  - `H_TOT` = `H_VIS`+`H_FP`+`H_SP`+`H_BP` = 800
  - `V_TOT` = 525
- All state updates occur only on `clk` edges where `pix_en`=1. With `pix_en`=0, every register holds, except that `frame_tick` clears.
- Stage 0 (counters):
  - `h_cnt` increments; at `H_TOT`-1 it wraps to 0.
  - When `h_cnt` wraps, `v_cnt` increments; at `V_TOT`-1 it wraps to 0.
  - `pix_x`=`h_cnt`, `pix_y`=`v_cnt`.
  - `de` is registered with the counters: (next_h < `H_VIS`) && (next_v < `V_VIS`).
- Stage 1 (output), registered on the same `pix_en` from stage-0 values before update:
  - `hsync` = `SYNC_POL` when `h_cnt` ∈ [`H_VIS`+`H_FP`, `H_VIS`+`H_FP`+`H_SP`) = [656,752), otherwise ~`SYNC_POL`.
  - `vsync` = `SYNC_POL` when `v_cnt` ∈ [490,492), otherwise ~`SYNC_POL`.
  - `rgb_out` = `de` ? `rgb_in` : 12'h000.
- `frame_tick` = 1 for exactly one `clk` cycle following the `pix_en` edge that moves the counters to (0,0).
- Counter arithmetic is 10-bit unsigned; all totals must be ≤ 1023.

## Timing
- Reset values:
  - `h_cnt`=`H_TOT`-1 (799), `v_cnt`=`V_TOT`-1 (524), so the first `pix_en` after reset lands on (0,0).
  - `de`=0, `hsync`=`vsync`=~`SYNC_POL` (1), `rgb_out`=0, `frame_tick`=0.
- Renderer contract: `rgb_in` must be valid for the coordinate on `pix_x`/`pix_y` by the next `pix_en`, which is a 4-`clk` budget. Colour latency from coordinate to pin is exactly one pixel period.
- Syncs and `rgb_out` change on the same `clk` edge, so relative alignment is zero cycles.
- `clr_n` asserted mid-frame: all outputs go to reset values immediately (asynchronously). On release, the raster restarts at (0,0) with the first `pix_en`. No partial line completes.
- `pix_en` asserted on consecutive cycles is legal: the block advances once per strobe regardless of spacing.

## Structure
- Package `vga_pkg`: the 640x480 timing constants, the derived `H_TOT`/`V_TOT`/sync window bounds, `SYNC_POL`, and the 12-bit `rgb_t` colour type. These are shared with the renderer and the divider.
- No sub-module. Both axis counters and the output register stage stay inline. The divider remains a separate block and drives `pix_en`.

## Test plan
- Reset, then strobe `pix_en` every 4 `clk` → after the first strobe `pix_x`=0, `pix_y`=0, `de`=1, `frame_tick` pulses for 1 cycle.
- Run one full line → `hsync` is low for exactly 96 strobes, starting when stage 0 saw `h_cnt`=656; the line period is 800 strobes = 3200 `clk`.
- Run one full frame → `vsync` is low for 2 lines (1600 strobes); the frame is 420000 strobes; `frame_tick` fires exactly once per frame.
- Drive `rgb_in`=12'hF00 constantly → `rgb_out`=F00 only on strobes following `de`=1, and 0 at `h_cnt`≥640 or `v_cnt`≥480. The first visible colour appears one strobe after (0,0).
- Hold `pix_en`=0 for 100 cycles mid-line → all outputs hold; `frame_tick` stays 0.
- Assert `clr_n`=0 at (300,200) → outputs take reset values that same cycle; after release, the next strobe gives (0,0).
